// File: rtl/screen_select.sv
// Screen selector: tracks which screen (menu, game, end) is active and
// forwards the matching VGA timing and pixel colour, delayed by one clock.
// Screen changes are requested by clicks or by the game-over pulse, but they
// only take effect at a frame start. This keeps a frame from showing two sources.
module screen_select #(
  parameter int START_X = 412,
  parameter int START_Y = 300,
  parameter int BACK_X  = 412,
  parameter int BACK_Y  = 500,
  parameter int BTN_W   = 200,
  parameter int BTN_H   = 60,
  parameter int CNT_W   = 11,
  parameter int RGB_B   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [11:0]      mouse_x,
  input  logic [11:0]      mouse_y,
  input  logic             mouse_left,
  input  logic             game_end,
  input  logic [1:0]       game_result,
  // menu-screen source (also the frame-timing reference)
  input  logic [CNT_W-1:0] vga_menu_hcount,
  input  logic [CNT_W-1:0] vga_menu_vcount,
  input  logic             vga_menu_hblnk,
  input  logic             vga_menu_vblnk,
  input  logic             vga_menu_hsync,
  input  logic             vga_menu_vsync,
  input  logic [RGB_B-1:0] rgb_menu,
  // game-screen source
  input  logic [CNT_W-1:0] vga_game_hcount,
  input  logic [CNT_W-1:0] vga_game_vcount,
  input  logic             vga_game_hblnk,
  input  logic             vga_game_vblnk,
  input  logic             vga_game_hsync,
  input  logic             vga_game_vsync,
  input  logic [RGB_B-1:0] rgb_game,
  // end-screen source
  input  logic [CNT_W-1:0] vga_end_hcount,
  input  logic [CNT_W-1:0] vga_end_vcount,
  input  logic             vga_end_hblnk,
  input  logic             vga_end_vblnk,
  input  logic             vga_end_hsync,
  input  logic             vga_end_vsync,
  input  logic [RGB_B-1:0] rgb_end,
  // selected output
  output logic [CNT_W-1:0] vga_out_hcount,
  output logic [CNT_W-1:0] vga_out_vcount,
  output logic             vga_out_hblnk,
  output logic             vga_out_vblnk,
  output logic             vga_out_hsync,
  output logic             vga_out_vsync,
  output logic [RGB_B-1:0] rgb_o,
  output logic [1:0]       screen_o,
  output logic [1:0]       result_o,
  output logic             game_run
);

  localparam logic [1:0] SCR_MENU = 2'b00;
  localparam logic [1:0] SCR_GAME = 2'b01;
  localparam logic [1:0] SCR_END  = 2'b10;

  // Button rectangles as 13-bit bounds. The extra bit keeps X+W from
  // wrapping when a button sits near the 12-bit coordinate limit.
  localparam logic [12:0] START_X_LO = 13'(START_X);
  localparam logic [12:0] START_X_HI = 13'(START_X + BTN_W);
  localparam logic [12:0] START_Y_LO = 13'(START_Y);
  localparam logic [12:0] START_Y_HI = 13'(START_Y + BTN_H);
  localparam logic [12:0] BACK_X_LO  = 13'(BACK_X);
  localparam logic [12:0] BACK_X_HI  = 13'(BACK_X + BTN_W);
  localparam logic [12:0] BACK_Y_LO  = 13'(BACK_Y);
  localparam logic [12:0] BACK_Y_HI  = 13'(BACK_Y + BTN_H);

  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hblnk;
    logic             vblnk;
    logic             hsync;
    logic             vsync;
    logic [RGB_B-1:0] rgb;
  } pix_t;

  // state registers
  logic [1:0] screen_q, screen_d;
  logic [1:0] next_scr_q, next_scr_d;
  logic [1:0] result_q, result_d;
  logic       game_run_q, game_run_d;
  logic       mouse_left_q;
  logic       armed_q, armed_d;
  pix_t       pix_q, pix_d;

  // decoded events
  logic [12:0] mx13, my13;
  logic        click;
  logic        in_start, in_back;
  logic        frame_start;
  logic        pending;
  pix_t        src_menu, src_game, src_end;

  // Rising-edge click detect. The armed flag stays low until the button has
  // been seen released, so a button held through reset release is not a click.
  always_comb begin
    armed_d = armed_q | ~mouse_left;
    click   = mouse_left & ~mouse_left_q & armed_q;
  end

  // Cursor hit tests against both buttons, with half-open ranges.
  always_comb begin
    mx13     = {1'b0, mouse_x};
    my13     = {1'b0, mouse_y};
    in_start = (mx13 >= START_X_LO) && (mx13 < START_X_HI) &&
               (my13 >= START_Y_LO) && (my13 < START_Y_HI);
    in_back  = (mx13 >= BACK_X_LO) && (mx13 < BACK_X_HI) &&
               (my13 >= BACK_Y_LO) && (my13 < BACK_Y_HI);
  end

  // The menu timing is the frame reference for all three aligned sources.
  always_comb begin
    frame_start = (vga_menu_hcount == '0) && (vga_menu_vcount == '0);
  end

  // Request logic. Only one request may be pending at a time. Events that do
  // not belong to the displayed screen are dropped.
  always_comb begin
    pending    = (next_scr_q != screen_q);
    next_scr_d = next_scr_q;
    result_d   = result_q;
    if (!pending) begin
      case (screen_q)
        SCR_MENU: begin
          if (click && in_start) next_scr_d = SCR_GAME;
        end
        SCR_GAME: begin
          if (game_end && (game_result != 2'b00)) begin
            next_scr_d = SCR_END;
            result_d   = game_result;
          end
        end
        SCR_END: begin
          if (click && in_back) next_scr_d = SCR_MENU;
        end
        default: next_scr_d = SCR_MENU;
      endcase
    end
  end

  // Displayed screen follows the request only at frame start. A request made
  // in the frame-start cycle itself takes effect at that frame start.
  always_comb begin
    screen_d   = frame_start ? next_scr_d : screen_q;
    game_run_d = (screen_d == SCR_GAME);
  end

  // Bundle each source so the output mux is one selection.
  always_comb begin
    src_menu = '{hcount: vga_menu_hcount, vcount: vga_menu_vcount,
                 hblnk: vga_menu_hblnk, vblnk: vga_menu_vblnk,
                 hsync: vga_menu_hsync, vsync: vga_menu_vsync,
                 rgb: rgb_menu};
    src_game = '{hcount: vga_game_hcount, vcount: vga_game_vcount,
                 hblnk: vga_game_hblnk, vblnk: vga_game_vblnk,
                 hsync: vga_game_hsync, vsync: vga_game_vsync,
                 rgb: rgb_game};
    src_end  = '{hcount: vga_end_hcount, vcount: vga_end_vcount,
                 hblnk: vga_end_hblnk, vblnk: vga_end_vblnk,
                 hsync: vga_end_hsync, vsync: vga_end_vsync,
                 rgb: rgb_end};
  end

  // Output mux. The select is the screen already displayed when the pixel
  // arrives, so the frame-start pixel still comes from the old source.
  always_comb begin
    case (screen_q)
      SCR_GAME: pix_d = src_game;
      SCR_END:  pix_d = src_end;
      default:  pix_d = src_menu;
    endcase
  end

  // State and output registers, with synchronous reset to the menu screen.
  always_ff @(posedge clk) begin
    if (rst) begin
      screen_q     <= SCR_MENU;
      next_scr_q   <= SCR_MENU;
      result_q     <= 2'b00;
      game_run_q   <= 1'b0;
      mouse_left_q <= 1'b0;
      armed_q      <= 1'b0;
      pix_q        <= '0;
    end else begin
      screen_q     <= screen_d;
      next_scr_q   <= frame_start ? screen_d : next_scr_d;
      result_q     <= result_d;
      game_run_q   <= game_run_d;
      mouse_left_q <= mouse_left;
      armed_q      <= armed_d;
      pix_q        <= pix_d;
    end
  end

  // Drive the output ports from the registered values.
  always_comb begin
    vga_out_hcount = pix_q.hcount;
    vga_out_vcount = pix_q.vcount;
    vga_out_hblnk  = pix_q.hblnk;
    vga_out_vblnk  = pix_q.vblnk;
    vga_out_hsync  = pix_q.hsync;
    vga_out_vsync  = pix_q.vsync;
    rgb_o          = pix_q.rgb;
    screen_o       = screen_q;
    result_o       = result_q;
    game_run       = game_run_q;
  end

endmodule

// File: tb/tb_screen_select.sv
// Directed bench for screen_select. A vector table runs the menu/game/end
// flow, and a short loop then covers one small full menu frame.
module tb_screen_select;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] mouse_x, mouse_y;
  logic        mouse_left, game_end;
  logic [1:0]  game_result;
  logic [10:0] vga_menu_hcount, vga_menu_vcount, vga_game_hcount, vga_game_vcount;
  logic [10:0] vga_end_hcount, vga_end_vcount;
  logic        vga_menu_hblnk, vga_menu_vblnk, vga_menu_hsync, vga_menu_vsync;
  logic        vga_game_hblnk, vga_game_vblnk, vga_game_hsync, vga_game_vsync;
  logic        vga_end_hblnk, vga_end_vblnk, vga_end_hsync, vga_end_vsync;
  logic [11:0] rgb_menu, rgb_game, rgb_end;
  logic [10:0] vga_out_hcount, vga_out_vcount;
  logic        vga_out_hblnk, vga_out_vblnk, vga_out_hsync, vga_out_vsync;
  logic [11:0] rgb_o;
  logic [1:0]  screen_o, result_o;
  logic        game_run;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  screen_select dut (
    .clk(clk), .rst(rst),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_left(mouse_left),
    .game_end(game_end), .game_result(game_result),
    .vga_menu_hcount(vga_menu_hcount), .vga_menu_vcount(vga_menu_vcount),
    .vga_menu_hblnk(vga_menu_hblnk), .vga_menu_vblnk(vga_menu_vblnk),
    .vga_menu_hsync(vga_menu_hsync), .vga_menu_vsync(vga_menu_vsync),
    .rgb_menu(rgb_menu),
    .vga_game_hcount(vga_game_hcount), .vga_game_vcount(vga_game_vcount),
    .vga_game_hblnk(vga_game_hblnk), .vga_game_vblnk(vga_game_vblnk),
    .vga_game_hsync(vga_game_hsync), .vga_game_vsync(vga_game_vsync),
    .rgb_game(rgb_game),
    .vga_end_hcount(vga_end_hcount), .vga_end_vcount(vga_end_vcount),
    .vga_end_hblnk(vga_end_hblnk), .vga_end_vblnk(vga_end_vblnk),
    .vga_end_hsync(vga_end_hsync), .vga_end_vsync(vga_end_vsync),
    .rgb_end(rgb_end),
    .vga_out_hcount(vga_out_hcount), .vga_out_vcount(vga_out_vcount),
    .vga_out_hblnk(vga_out_hblnk), .vga_out_vblnk(vga_out_vblnk),
    .vga_out_hsync(vga_out_hsync), .vga_out_vsync(vga_out_vsync),
    .rgb_o(rgb_o),
    .screen_o(screen_o), .result_o(result_o), .game_run(game_run)
  );

  // source ids used for the expected pixel: 3 means all-zero (reset)
  localparam logic [1:0] S_MENU = 2'd0, S_GAME = 2'd1, S_END = 2'd2, S_ZERO = 2'd3;

  typedef struct packed {
    logic        rst;
    logic [10:0] h;
    logic [10:0] v;
    logic [11:0] mx;
    logic [11:0] my;
    logic        ml;
    logic        ge;
    logic [1:0]  gr;
    logic [1:0]  exp_scr;
    logic [1:0]  exp_res;
    logic [1:0]  exp_src;
  } vec_t;

  vec_t vecs[$];

  // Each source gets a distinct timing and colour pattern. This shows which
  // source the mux picked.
  function automatic logic [37:0] src_pix(input logic [1:0] src,
                                          input logic [10:0] h, input logic [10:0] v);
    case (src)
      S_MENU:  return {h, v, h[0], v[0], h[1], v[1], 12'h123};
      S_GAME:  return {h ^ 11'h7FF, v ^ 11'h7FF, ~h[0], ~v[0], ~h[1], ~v[1], 12'h456};
      S_END:   return {h ^ 11'h555, v ^ 11'h2AA, h[1], v[1], h[0], v[0], 12'h789};
      default: return 38'd0;
    endcase
  endfunction

  task automatic drive(input vec_t t);
    logic [37:0] p;
    rst = t.rst; mouse_x = t.mx; mouse_y = t.my; mouse_left = t.ml;
    game_end = t.ge; game_result = t.gr;
    p = src_pix(S_MENU, t.h, t.v);
    {vga_menu_hcount, vga_menu_vcount, vga_menu_hblnk, vga_menu_vblnk,
     vga_menu_hsync, vga_menu_vsync, rgb_menu} = p;
    p = src_pix(S_GAME, t.h, t.v);
    {vga_game_hcount, vga_game_vcount, vga_game_hblnk, vga_game_vblnk,
     vga_game_hsync, vga_game_vsync, rgb_game} = p;
    p = src_pix(S_END, t.h, t.v);
    {vga_end_hcount, vga_end_vcount, vga_end_hblnk, vga_end_vblnk,
     vga_end_hsync, vga_end_vsync, rgb_end} = p;
  endtask

  task automatic check(input string name, input int idx,
                       input logic [37:0] act, input logic [37:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
  endtask

  // Apply one vector for one clock, then compare 1 ns after the edge.
  task automatic run_vec(input vec_t t, input int idx);
    logic [37:0] act;
    drive(t);
    @(posedge clk);
    #1;
    act = {vga_out_hcount, vga_out_vcount, vga_out_hblnk, vga_out_vblnk,
           vga_out_hsync, vga_out_vsync, rgb_o};
    check("pix", idx, act, src_pix(t.exp_src, t.h, t.v));
    check("screen", idx, 38'(screen_o), 38'(t.exp_scr));
    check("result", idx, 38'(result_o), 38'(t.exp_res));
    check("game_run", idx, 38'(game_run), 38'(t.exp_scr == 2'd1));
    $display("vec %0d: rst=%0b h=%0d v=%0d m=(%0d,%0d,%0b) ge=%0b gr=%0b -> scr=%0d res=%0d run=%0b rgb=%h",
             idx, t.rst, t.h, t.v, t.mx, t.my, t.ml, t.ge, t.gr,
             screen_o, result_o, game_run, rgb_o);
  endtask

  // rst, h, v, mx, my, ml, ge, gr, exp_scr, exp_res, exp_src
  task automatic add(input logic r, input int h, input int v, input int mx, input int my,
                     input logic ml, input logic ge, input logic [1:0] gr,
                     input logic [1:0] es, input logic [1:0] er, input logic [1:0] src);
    vec_t t;
    t.rst = r; t.h = 11'(h); t.v = 11'(v); t.mx = 12'(mx); t.my = 12'(my);
    t.ml = ml; t.ge = ge; t.gr = gr; t.exp_scr = es; t.exp_res = er; t.exp_src = src;
    vecs.push_back(t);
  endtask

  initial begin
    vec_t t;
    // reset, with the button held on start through reset release
    add(1, 5, 3, 500, 320, 1, 0, 2'b00, 0, 0, S_ZERO);   // 0
    add(1, 0, 0, 500, 320, 1, 0, 2'b00, 0, 0, S_ZERO);   // 1
    add(0, 5, 3, 500, 320, 1, 0, 2'b00, 0, 0, S_MENU);   // 2
    add(0, 0, 0, 500, 320, 1, 0, 2'b00, 0, 0, S_MENU);   // 3 held button: no switch
    add(0, 5, 3, 500, 320, 0, 0, 2'b00, 0, 0, S_MENU);   // 4
    // clicks just outside the start button on both x edges
    add(0, 5, 3, 411, 320, 1, 0, 2'b00, 0, 0, S_MENU);   // 5
    add(0, 5, 3, 411, 320, 0, 0, 2'b00, 0, 0, S_MENU);   // 6
    add(0, 0, 0, 411, 320, 0, 0, 2'b00, 0, 0, S_MENU);   // 7
    add(0, 5, 3, 612, 320, 1, 0, 2'b00, 0, 0, S_MENU);   // 8
    add(0, 5, 3, 612, 320, 0, 0, 2'b00, 0, 0, S_MENU);   // 9
    add(0, 0, 0, 612, 320, 0, 0, 2'b00, 0, 0, S_MENU);   // 10
    // click on the start button corner; switch waits for frame start
    add(0, 5, 3, 412, 300, 1, 0, 2'b00, 0, 0, S_MENU);   // 11
    add(0, 6, 3, 412, 300, 1, 0, 2'b00, 0, 0, S_MENU);   // 12
    add(0, 0, 0, 412, 300, 1, 0, 2'b00, 1, 0, S_MENU);   // 13 frame-start pixel: old source
    add(0, 1, 0, 0, 0, 0, 0, 2'b00, 1, 0, S_GAME);       // 14
    // game end with result 00 is ignored
    add(0, 5, 3, 0, 0, 0, 1, 2'b00, 1, 0, S_GAME);       // 15
    add(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, S_GAME);       // 16
    // draw, then a second game_end while the request is pending
    add(0, 5, 3, 0, 0, 0, 1, 2'b11, 1, 3, S_GAME);       // 17
    add(0, 6, 3, 0, 0, 0, 1, 2'b01, 1, 3, S_GAME);       // 18
    add(0, 0, 0, 0, 0, 0, 0, 2'b00, 2, 3, S_GAME);       // 19
    add(0, 1, 0, 0, 0, 0, 0, 2'b00, 2, 3, S_END);        // 20
    // hold back button across several frames: one transition only
    add(0, 5, 3, 500, 520, 1, 0, 2'b00, 2, 3, S_END);    // 21
    add(0, 0, 0, 500, 520, 1, 0, 2'b00, 0, 3, S_END);    // 22
    add(0, 5, 3, 500, 520, 1, 0, 2'b00, 0, 3, S_MENU);   // 23
    add(0, 0, 0, 500, 520, 1, 0, 2'b00, 0, 3, S_MENU);   // 24
    add(0, 5, 3, 500, 520, 1, 0, 2'b00, 0, 3, S_MENU);   // 25
    add(0, 0, 0, 500, 520, 1, 0, 2'b00, 0, 3, S_MENU);   // 26
    // click landing in the frame-start cycle switches at once
    add(0, 5, 3, 500, 320, 0, 0, 2'b00, 0, 3, S_MENU);   // 27
    add(0, 0, 0, 500, 320, 1, 0, 2'b00, 1, 3, S_MENU);   // 28
    add(0, 1, 0, 500, 320, 1, 0, 2'b00, 1, 3, S_GAME);   // 29
    // back-button click during the game is ignored
    add(0, 5, 3, 500, 520, 0, 0, 2'b00, 1, 3, S_GAME);   // 30
    add(0, 5, 3, 500, 520, 1, 0, 2'b00, 1, 3, S_GAME);   // 31
    add(0, 0, 0, 500, 520, 1, 0, 2'b00, 1, 3, S_GAME);   // 32
    // P1 win, go back to the menu
    add(0, 5, 3, 0, 0, 0, 1, 2'b01, 1, 1, S_GAME);       // 33
    add(0, 0, 0, 0, 0, 0, 0, 2'b00, 2, 1, S_GAME);       // 34
    add(0, 5, 3, 500, 520, 1, 0, 2'b00, 2, 1, S_END);    // 35
    add(0, 0, 0, 500, 520, 1, 0, 2'b00, 0, 1, S_END);    // 36
    // pending start request discarded by reset mid-frame
    add(0, 5, 3, 500, 320, 0, 0, 2'b00, 0, 1, S_MENU);   // 37
    add(0, 5, 3, 500, 320, 1, 0, 2'b00, 0, 1, S_MENU);   // 38
    add(1, 6, 3, 500, 320, 1, 0, 2'b00, 0, 0, S_ZERO);   // 39
    add(1, 0, 0, 500, 320, 1, 0, 2'b00, 0, 0, S_ZERO);   // 40
    add(0, 7, 3, 500, 320, 0, 0, 2'b00, 0, 0, S_MENU);   // 41
    add(0, 0, 0, 500, 320, 0, 0, 2'b00, 0, 0, S_MENU);   // 42
    add(0, 1, 0, 500, 320, 0, 0, 2'b00, 0, 0, S_MENU);   // 43

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // one small full frame in the menu: each pixel comes back one clock later
    for (int v = 0; v < 3; v++) begin
      for (int h = 0; h < 4; h++) begin
        t = '0;
        t.h = 11'(h); t.v = 11'(v); t.exp_src = S_MENU;
        run_vec(t, 100 + v * 4 + h);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/screen_select.md
SCREEN_SELECT -- requirements
Module: screen_select

Interface
REQ-001 Parameter START_X, default 412, left edge (px) of menu "start" button.
REQ-002 Parameter START_Y, default 300, top edge (px) of menu "start" button.
REQ-003 Parameter BACK_X, default 412, left edge (px) of end-screen "back to menu" button.
REQ-004 Parameter BACK_Y, default 500, top edge (px) of end-screen "back to menu" button.
REQ-005 Parameter BTN_W, default 200, width (px) of both buttons; BTN_H, default 60, height (px) of both buttons.
REQ-006 Clock and reset: clk  in  1  system/pixel clock; rst  in  1  synchronous, active-high reset.
REQ-007 mouse_x  in  12  cursor x; mouse_y  in  12  cursor y; mouse_left  in  1  left button level.
REQ-008 game_end  in  1  one-cycle pulse, game finished; game_result  in  2  01 = P1 win, 10 = P2 win, 11 = draw, sampled with game_end.
REQ-009 vga_menu  vga_if.in  menu-screen timing; rgb_menu  in  RGB_B  menu pixel colour.
REQ-010 vga_game  vga_if.in  game-screen timing; rgb_game  in  RGB_B  game pixel colour.
REQ-011 vga_end  vga_if.in  end-screen timing (win/lose/draw renderer); rgb_end  in  RGB_B  end-screen pixel colour.
REQ-012 vga_out  vga_if.out  selected timing; rgb_o  out  RGB_B  selected colour.
REQ-013 screen_o  out  2  active screen: 00 MENU, 01 GAME, 10 END; result_o  out  2  latched result for end-screen text; game_run  out  1  high while screen_o == GAME.

Function
REQ-014 All three vga inputs SHALL be treated as mutually aligned; vga_menu timing alone SHALL be used for frame detection.
REQ-015 FSM states: MENU, GAME, END; requested state (next_scr) and displayed state (screen_o) SHALL be held in separate registers.
REQ-016 Click = rising edge of mouse_left (registered previous value); level-held button SHALL produce exactly one click.
REQ-017 Hit test: START_X <= mouse_x < START_X+BTN_W and START_Y <= mouse_y < START_Y+BTN_H (likewise BACK_*); 13-bit unsigned compare, no wrap.
REQ-018 MENU -> GAME request on click inside start button while screen_o == MENU.
REQ-019 GAME -> END request on game_end while screen_o == GAME; game_result SHALL be latched into result_o in the same cycle.
REQ-020 game_end with game_result == 00 SHALL be ignored (no request, result_o unchanged).
REQ-021 END -> MENU request on click inside back button while screen_o == END.
REQ-022 Clicks/game_end not matching the current screen SHALL be ignored; a second event while a request is pending SHALL be ignored.
REQ-023 screen_o SHALL load next_scr only on the cycle vga_menu.hcount == 0 and vga_menu.vcount == 0 (frame start); no mid-frame switch.
REQ-024 Request and frame start in the same cycle: switch SHALL occur at that frame start.
REQ-025 game_run SHALL equal (screen_o == GAME), registered with screen_o.
REQ-026 Output mux: vga_out and rgb_o SHALL be the source selected by screen_o, registered; latency exactly 1 clk for all of hcount, vcount, hblnk, vblnk, hsync, vsync, rgb.
REQ-027 The mux select used for a pixel SHALL be the screen_o value valid in the cycle that pixel enters the block.
REQ-028 result_o SHALL hold its value through END -> MENU and until the next valid game_end.

Reset
REQ-029 On rst: screen_o = MENU, next_scr = MENU, result_o = 00, game_run = 0, click-edge register = 0.
REQ-030 On rst: vga_out hcount/vcount = 0, hblnk/vblnk/hsync/vsync = 0, rgb_o = 0.
REQ-031 rst mid-frame or with a pending request SHALL discard the request; first output after release reflects MENU source one cycle later.
REQ-032 mouse_left held high through rst release SHALL NOT produce a click.

Verification
REQ-033 Reset then full frame: rgb_menu = 0x123, others distinct -> rgb_o = 0x123 one cycle after each input pixel, screen_o = 00.
REQ-034 Click at (500,320) mid-frame in MENU -> screen_o stays 00 until next hcount=vcount=0, then 01 and game_run = 1; rgb_o switches on that pixel + 1 clk.
REQ-035 Click at (411,320) and (612,320) in MENU -> no request (edge exclusion); click at (412,300) -> request.
REQ-036 In GAME pulse game_end with result 11 -> result_o = 11 immediately, screen_o = 10 at next frame start; game_end with result 00 -> no change.
REQ-037 In END hold mouse_left high inside back button for 3 frames -> single transition to MENU; result_o stays 11.
REQ-038 Assert rst with pending MENU->GAME request mid-frame -> after release screen_o = 00 through next frame start, all outputs 0 during reset.
